draw_scheduler: RTL and testbench



---
 rtl/draw_scheduler.sv | 227 ++++++++++++++++++++++
 tb/tb_draw_scheduler.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/draw_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : draw_scheduler
// Purpose  : Front-end controller for one circle-drawing engine. It queues
//            draw commands in a FIFO, runs one engine job at a time using the
//            start/done handshake, and arbitrates the shared VGA plot port.
//            An optional full-screen clear sweep can also drive that port.
// Ports    : clk, rst_n (synchronous, active-low)
//            cmd_*         valid/ready command input (x, y, radius, colour)
//            clear_req     one-cycle pulse requesting a screen clear
//            eng_start/eng_done, eng_centre_*/eng_radius/eng_colour to engine
//            eng_vga_*     engine pixel stream, vga_* arbitrated pixel output
//            busy, jobs_done  status
// Options  : `define DRAW_SCHED_CLEAR_EN to build the clear sweep.
// Revision : 1.0 - initial release
// ============================================================================
module draw_scheduler #(
    parameter int FIFO_DEPTH = 4,
    parameter int SCREEN_W   = 160,
    parameter int SCREEN_H   = 120
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [7:0]  cmd_x,
    input  logic [6:0]  cmd_y,
    input  logic [7:0]  cmd_r,
    input  logic [2:0]  cmd_colour,
    input  logic        clear_req,
    output logic        eng_start,
    input  logic        eng_done,
    output logic [7:0]  eng_centre_x,
    output logic [6:0]  eng_centre_y,
    output logic [7:0]  eng_radius,
    output logic [2:0]  eng_colour,
    input  logic [7:0]  eng_vga_x,
    input  logic [6:0]  eng_vga_y,
    input  logic [2:0]  eng_vga_colour,
    input  logic        eng_vga_plot,
    output logic [7:0]  vga_x,
    output logic [6:0]  vga_y,
    output logic [2:0]  vga_colour,
    output logic        vga_plot,
    output logic        busy,
    output logic [15:0] jobs_done
);

    localparam int             PTR_W    = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LAUNCH  = 3'd1,
        S_WAIT    = 3'd2,
        S_RELEASE = 3'd3
`ifdef DRAW_SCHED_CLEAR_EN
        , S_CLEAR = 3'd4
`endif
    } state_t;

    state_t state_q, state_d;

    // Command FIFO: entry = {x, y, r, colour}
    logic [25:0]      fifo_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]   count_q;
    logic             w_push, w_pop;
    logic [25:0]      w_head;

    logic [15:0]      jobs_done_q;
    logic             w_clear_pend;

    assign cmd_ready = (count_q != FULL_CNT);
    assign w_push    = cmd_valid && cmd_ready;
    assign w_head    = fifo_q[rd_ptr_q];

`ifdef DRAW_SCHED_CLEAR_EN
    localparam logic [7:0] X_LAST = 8'(SCREEN_W - 1);
    localparam logic [6:0] Y_LAST = 7'(SCREEN_H - 1);

    logic       clear_pend_q;
    logic [7:0] cx_q;
    logic [6:0] cy_q;
    logic       w_start_clear;

    assign w_clear_pend = clear_pend_q;

    // Entering CLEAR consumes the pending request; a pulse landing in that
    // same cycle is merged into the sweep that is just starting.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            clear_pend_q <= 1'b0;
            cx_q         <= 8'd0;
            cy_q         <= 7'd0;
        end else begin
            if (w_start_clear) begin
                clear_pend_q <= 1'b0;
            end else if (clear_req) begin
                clear_pend_q <= 1'b1;
            end
            if (w_start_clear) begin
                cx_q <= 8'd0;
                cy_q <= 7'd0;
            end else if (state_q == S_CLEAR) begin
                if (cx_q == X_LAST) begin
                    cx_q <= 8'd0;
                    cy_q <= cy_q + 7'd1;
                end else begin
                    cx_q <= cx_q + 8'd1;
                end
            end
        end
    end
`else
    // Clear feature absent: request input and screen size have no effect.
    logic [15:0] w_unused;
    assign w_unused     = {clear_req, 15'(SCREEN_W + SCREEN_H)};
    assign w_clear_pend = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Next-state and output decode
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        w_pop      = 1'b0;
        eng_start  = 1'b0;
        vga_x      = 8'd0;
        vga_y      = 7'd0;
        vga_colour = 3'd0;
        vga_plot   = 1'b0;
`ifdef DRAW_SCHED_CLEAR_EN
        w_start_clear = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
`ifdef DRAW_SCHED_CLEAR_EN
                if (w_clear_pend) begin
                    w_start_clear = 1'b1;
                    state_d       = S_CLEAR;
                end else
`endif
                if (count_q != '0) begin
                    w_pop   = 1'b1;
                    state_d = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                eng_start = 1'b1;
                state_d   = S_WAIT;
            end
            S_WAIT: begin
                eng_start  = 1'b1;
                vga_x      = eng_vga_x;
                vga_y      = eng_vga_y;
                vga_colour = eng_vga_colour;
                vga_plot   = eng_vga_plot;
                if (eng_done) begin
                    state_d = S_RELEASE;
                end
            end
            S_RELEASE: begin
                state_d = S_IDLE;
            end
`ifdef DRAW_SCHED_CLEAR_EN
            S_CLEAR: begin
                vga_x    = cx_q;
                vga_y    = cy_q;
                vga_plot = 1'b1;
                if ((cx_q == X_LAST) && (cy_q == Y_LAST)) begin
                    state_d = S_IDLE;
                end
            end
`endif
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State, FIFO pointers, job parameters and completion counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            eng_centre_x <= 8'd0;
            eng_centre_y <= 7'd0;
            eng_radius   <= 8'd0;
            eng_colour   <= 3'd0;
            jobs_done_q  <= 16'd0;
        end else begin
            state_q <= state_d;
            if (w_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (w_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
                {eng_centre_x, eng_centre_y, eng_radius, eng_colour} <= w_head;
            end
            case ({w_push, w_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            if (state_q == S_RELEASE) begin
                jobs_done_q <= jobs_done_q + 16'd1;
            end
        end
    end

    // Storage needs no reset: the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            fifo_q[wr_ptr_q] <= {cmd_x, cmd_y, cmd_r, cmd_colour};
        end
    end

    assign jobs_done = jobs_done_q;
    assign busy      = (state_q != S_IDLE) || (count_q != '0) || w_clear_pend;

endmodule
`default_nettype wire

// File: tb/tb_draw_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_draw_scheduler
// Purpose  : Self-checking bench for draw_scheduler. A queue-based reference
//            model predicts every output each cycle; directed scenarios add
//            hand-computed literal expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_draw_scheduler;

    localparam int DEPTH = 4;
    localparam int W     = 160;
    localparam int H     = 120;
`ifdef DRAW_SCHED_CLEAR_EN
    localparam bit CLR = 1'b1;
`else
    localparam bit CLR = 1'b0;
`endif

    typedef struct packed {
        logic [7:0] x;
        logic [6:0] y;
        logic [7:0] r;
        logic [2:0] c;
    } cmd_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid, cmd_ready;
    logic [7:0]  cmd_x;
    logic [6:0]  cmd_y;
    logic [7:0]  cmd_r;
    logic [2:0]  cmd_colour;
    logic        clear_req;
    logic        eng_start, eng_done;
    logic [7:0]  eng_centre_x;
    logic [6:0]  eng_centre_y;
    logic [7:0]  eng_radius;
    logic [2:0]  eng_colour;
    logic [7:0]  eng_vga_x;
    logic [6:0]  eng_vga_y;
    logic [2:0]  eng_vga_colour;
    logic        eng_vga_plot;
    logic [7:0]  vga_x;
    logic [6:0]  vga_y;
    logic [2:0]  vga_colour;
    logic        vga_plot;
    logic        busy;
    logic [15:0] jobs_done;

    always #5 clk = ~clk;

    draw_scheduler #(.FIFO_DEPTH(DEPTH), .SCREEN_W(W), .SCREEN_H(H)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_r(cmd_r), .cmd_colour(cmd_colour),
        .clear_req(clear_req),
        .eng_start(eng_start), .eng_done(eng_done),
        .eng_centre_x(eng_centre_x), .eng_centre_y(eng_centre_y),
        .eng_radius(eng_radius), .eng_colour(eng_colour),
        .eng_vga_x(eng_vga_x), .eng_vga_y(eng_vga_y),
        .eng_vga_colour(eng_vga_colour), .eng_vga_plot(eng_vga_plot),
        .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot),
        .busy(busy), .jobs_done(jobs_done)
    );

    int n_pass  = 0;
    int n_total = 0;
    bit cmp_en  = 1'b0;
    int done_pct = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // ------------------------------------------------------------------
    // Reference model: a queue of commands, the job in flight (how long it
    // has been running, whether it is finishing), and a pixel index for the
    // clear sweep whose coordinates follow from division by the width.
    // ------------------------------------------------------------------
    cmd_t        m_q[$];
    cmd_t        m_cur, m_inc;
    bit          m_job, m_rel, m_pend, m_push, m_enter;
    int          m_t, m_clr_left, m_pix;
    int unsigned m_jobs;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_q.delete();
            m_cur = '0; m_job = 0; m_rel = 0; m_t = 0;
            m_clr_left = 0; m_pix = 0; m_pend = 0; m_jobs = 0;
        end else begin
            m_push  = cmd_valid && (m_q.size() < DEPTH);
            m_inc   = {cmd_x, cmd_y, cmd_r, cmd_colour};
            m_enter = 0;
            if (m_rel) begin
                m_jobs = (m_jobs + 1) % 65536;
                m_job = 0; m_rel = 0;
            end else if (m_job) begin
                if (m_t == 0) m_t = 1;
                else if (eng_done) m_rel = 1;
            end else if (m_clr_left > 0) begin
                m_pix++; m_clr_left--;
            end else if (m_pend) begin
                m_clr_left = W * H; m_pix = 0; m_enter = 1;
            end else if (m_q.size() > 0) begin
                m_cur = m_q.pop_front();
                m_job = 1; m_t = 0;
            end
            if (CLR) m_pend = m_enter ? 1'b0 : (m_pend | clear_req);
            if (m_push) m_q.push_back(m_inc);
        end
    end

    bit e_wait, e_clr;
    always @(negedge clk) begin
        if (cmp_en) begin
            e_wait = m_job && (m_t == 1) && !m_rel;
            e_clr  = (m_clr_left > 0);
            chk("cmd_ready", cmd_ready, m_q.size() < DEPTH);
            chk("eng_start", eng_start, m_job && !m_rel);
            chk("eng_params", {eng_centre_x, eng_centre_y, eng_radius, eng_colour}, m_cur);
            chk("vga_plot", vga_plot, e_wait ? eng_vga_plot : e_clr);
            chk("vga_x", vga_x, e_wait ? eng_vga_x : (e_clr ? m_pix % W : 0));
            chk("vga_y", vga_y, e_wait ? eng_vga_y : (e_clr ? m_pix / W : 0));
            chk("vga_colour", vga_colour, e_wait ? eng_vga_colour : 0);
            chk("busy", busy, m_job || e_clr || (m_q.size() != 0) || m_pend);
            chk("jobs_done", jobs_done, m_jobs);
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers: inputs change 1 time unit after each rising edge
    // ------------------------------------------------------------------
    task automatic step();
        @(posedge clk);
        #1;
        clear_req      = 1'b0;
        eng_vga_x      = 8'($urandom);
        eng_vga_y      = 7'($urandom);
        eng_vga_colour = 3'($urandom);
        eng_vga_plot   = 1'($urandom);
        eng_done       = ($urandom_range(99) < done_pct);
    endtask

    task automatic push_cmd(input cmd_t c);
        int k = 0;
        bit ok = 0;
        cmd_valid = 1'b1;
        {cmd_x, cmd_y, cmd_r, cmd_colour} = c;
        while (!ok && k < 500) begin
            ok = cmd_ready;
            step();
            k++;
        end
        cmd_valid = 1'b0;
        if (!ok) chk("push_timeout", ok, 1);
    endtask

    task automatic wait_idle(input int budget);
        int k = 0;
        while (busy && k < budget) begin
            step();
            k++;
        end
        chk("idle_timeout", busy, 0);
    endtask

    function automatic cmd_t rnd_cmd();
        return {8'($urandom), 7'($urandom), 8'($urandom), 3'($urandom)};
    endfunction

    int plots, first_x, first_y, last_x, last_y, starts;

    initial begin
        rst_n = 1'b0; cmd_valid = 1'b0; clear_req = 1'b0; eng_done = 1'b0;
        cmd_x = '0; cmd_y = '0; cmd_r = '0; cmd_colour = '0;
        eng_vga_x = '0; eng_vga_y = '0; eng_vga_colour = '0; eng_vga_plot = 1'b0;
        step(); step();
        rst_n  = 1'b1;
        cmp_en = 1'b1;
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_jobs_done", jobs_done, 0);
        chk("rst_eng_start", eng_start, 0);

        // One job: start appears two cycles after the push cycle
        done_pct = 0;
        push_cmd({8'd80, 7'd60, 8'd10, 3'd3});
        chk("t1_start_early", eng_start, 0);
        step();
        chk("t1_start", eng_start, 1);
        chk("t1_x", eng_centre_x, 80);
        chk("t1_y", eng_centre_y, 60);
        chk("t1_r", eng_radius, 10);
        chk("t1_colour", eng_colour, 3);
        step(); step(); step();
        chk("t1_start_held", eng_start, 1);
        eng_done = 1'b1;
        step();
        chk("t1_release_start", eng_start, 0);
        chk("t1_release_plot", vga_plot, 0);
        step();
        chk("t1_jobs", jobs_done, 1);
        chk("t1_busy", busy, 0);

        // Fill: one job in the engine plus four queued leaves the FIFO full
        for (int i = 0; i < 5; i++) push_cmd(rnd_cmd());
        chk("t2_full", cmd_ready, 0);
        chk("t2_running", eng_start, 1);
        done_pct = 25;
        push_cmd(rnd_cmd());
        wait_idle(3000);
        chk("t2_jobs", jobs_done, 7);

`ifdef DRAW_SCHED_CLEAR_EN
        // Idle clear sweep
        done_pct = 20;
        clear_req = 1'b1;
        step();
        plots = 0; first_x = -1; first_y = -1; last_x = -1; last_y = -1;
        for (int k = 0; k < 25000 && busy; k++) begin
            if (vga_plot) begin
                if (plots == 0) begin first_x = vga_x; first_y = vga_y; end
                last_x = vga_x; last_y = vga_y;
                plots++;
            end
            step();
        end
        chk("clr_plots", plots, 19200);
        chk("clr_first_x", first_x, 0);
        chk("clr_first_y", first_y, 0);
        chk("clr_last_x", last_x, 159);
        chk("clr_last_y", last_y, 119);
        chk("clr_busy", busy, 0);

        // Clear requested mid-job is deferred; queued job runs after it
        done_pct = 0;
        push_cmd(rnd_cmd());
        push_cmd(rnd_cmd());
        step(); step();
        clear_req = 1'b1;
        step(); step(); step();
        eng_done = 1'b1;
        done_pct = 30;
        wait_idle(25000);
        chk("clr_wait_jobs", jobs_done, 9);
`else
        // Clear requests have no effect
        clear_req = 1'b1;
        step();
        for (int k = 0; k < 3; k++) begin
            chk("noclr_busy", busy, 0);
            chk("noclr_plot", vga_plot, 0);
            step();
        end
`endif

        // Reset while a job runs with two more queued
        done_pct = 0;
        for (int i = 0; i < 3; i++) push_cmd(rnd_cmd());
        step(); step(); step();
        rst_n = 1'b0;
        step();
        chk("rst_mid_start", eng_start, 0);
        chk("rst_mid_plot", vga_plot, 0);
        chk("rst_mid_ready", cmd_ready, 1);
        chk("rst_mid_jobs", jobs_done, 0);
        chk("rst_mid_busy", busy, 0);
        rst_n = 1'b1;
        done_pct = 30;
        starts = 0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (eng_start) starts++;
        end
        chk("rst_mid_no_launch", starts, 0);

        // Randomized traffic
        done_pct = 20;
        for (int k = 0; k < 3000; k++) begin
            step();
            cmd_valid = 1'($urandom);
            {cmd_x, cmd_y, cmd_r, cmd_colour} = rnd_cmd();
            if (!CLR) clear_req = ($urandom_range(15) == 0);
        end
        cmd_valid = 1'b0;
        wait_idle(3000);

        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
